// File: rtl/eth_avalon_txdma_pkg.sv
// Shared types and FIFO word layout for the transmit DMA read engine.
package eth_avalon_txdma_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        DRAIN = 2'd2
    } state_t;

    localparam int unsigned DATA_LSB = 0;
    localparam int unsigned BCNT_LSB = 32;
    localparam int unsigned SOP_BIT  = 34;
    localparam int unsigned EOP_BIT  = 35;
    localparam int unsigned WORD_W   = 36;

endpackage

// File: rtl/eth_avalon_txdma_space.sv
// Free-space check: a burst may issue only if the FIFO can absorb it plus
// everything still in flight, with SLACK words of margin for wrusedw latency.
module eth_avalon_txdma_space #(
    parameter int unsigned FIFO_AW = 10,
    parameter int unsigned SLACK   = 4
) (
    input  logic [FIFO_AW-1:0] i_wrusedw,
    input  logic               i_wrfull,
    input  logic [FIFO_AW:0]   i_outstanding,
    input  logic [6:0]         i_burst,
    output logic               o_burst_ok
);

    localparam int unsigned SW = FIFO_AW + 8;

    logic [SW-1:0] w_depth;
    logic [SW-1:0] w_used;
    logic [SW-1:0] w_free;
    logic [SW-1:0] w_need;

    assign w_depth = SW'(1) << FIFO_AW;
    assign w_used  = SW'(i_wrusedw) + SW'(i_outstanding);
    // Saturate at zero so an over-committed FIFO never wraps to "lots free".
    assign w_free  = (w_used >= w_depth) ? '0 : (w_depth - w_used);
    assign w_need  = SW'(i_burst) + SW'(SLACK);

    assign o_burst_ok = !i_wrfull && (w_free >= w_need);

endmodule

// File: rtl/eth_avalon_txdma_reader.sv
// Transmit DMA reader: bursts a frame buffer from Avalon-MM into the TX FIFO.
// Optional ETH_TXDMA_BSWAP_EN byte-reverses each read word for big-endian buffers.
module eth_avalon_txdma_reader
    import eth_avalon_txdma_pkg::*;
#(
    parameter int unsigned FIFO_AW = 10,
    parameter int unsigned BURST   = 8,
    parameter int unsigned SLACK   = 4
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               cmd_valid,
    output logic               cmd_ready,
    input  logic [31:0]        cmd_addr,
    input  logic [15:0]        cmd_len,
    output logic               done,
    output logic [31:0]        av_address,
    output logic               av_read,
    output logic [6:0]         av_burstcount,
    input  logic               av_waitrequest,
    input  logic [31:0]        av_readdata,
    input  logic               av_readdatavalid,
    output logic [35:0]        fifo_data,
    output logic               fifo_wrreq,
    input  logic [FIFO_AW-1:0] fifo_wrusedw,
    input  logic               fifo_wrfull
);

    localparam int unsigned OW = FIFO_AW + 1;

    state_t        r_state;
    logic          r_cmd_ready;
    logic [31:0]   r_addr;
    logic [14:0]   r_words;
    logic [14:0]   r_req_left;
    logic [14:0]   r_wr_idx;
    logic [1:0]    r_last_bcnt;
    logic [OW-1:0] r_outstanding;
    logic          r_av_read;
    logic [6:0]    r_burst;

    logic [14:0]       w_cmd_words;
    logic [1:0]        w_cmd_bcnt;
    logic [6:0]        w_burst;
    logic              w_burst_ok;
    logic              w_accept;
    logic              w_wr;
    logic              w_sop;
    logic              w_eop;
    logic [31:0]       w_data;
    logic [WORD_W-1:0] w_word;
    logic [OW-1:0]     w_out_next;

    assign w_cmd_words = 15'((17'(cmd_len) + 17'd3) >> 2);
    assign w_cmd_bcnt  = 2'(cmd_len - 16'd1);
    assign w_burst     = (r_req_left >= 15'(BURST)) ? 7'(BURST) : r_req_left[6:0];
    assign w_accept    = r_av_read && !av_waitrequest;
    assign w_wr        = av_readdatavalid && (r_outstanding != '0);
    assign w_sop       = (r_wr_idx == '0);
    assign w_eop       = (r_wr_idx == (r_words - 15'd1));

`ifdef ETH_TXDMA_BSWAP_EN
    assign w_data = {av_readdata[7:0], av_readdata[15:8], av_readdata[23:16], av_readdata[31:24]};
`else
    assign w_data = av_readdata;
`endif

    eth_avalon_txdma_space #(
        .FIFO_AW(FIFO_AW),
        .SLACK  (SLACK)
    ) u_space (
        .i_wrusedw    (fifo_wrusedw),
        .i_wrfull     (fifo_wrfull),
        .i_outstanding(r_outstanding),
        .i_burst      (w_burst),
        .o_burst_ok   (w_burst_ok)
    );

    always_comb begin
        w_word = '0;
        if (w_wr) begin
            w_word[DATA_LSB +: 32] = w_data;
            w_word[BCNT_LSB +: 2]  = w_eop ? r_last_bcnt : 2'b00;
            w_word[SOP_BIT]        = w_sop;
            w_word[EOP_BIT]        = w_eop;
        end
    end

    // Accept and data beat in the same cycle net out here.
    always_comb begin
        w_out_next = r_outstanding;
        if (w_accept) w_out_next = w_out_next + OW'(r_burst);
        if (w_wr)     w_out_next = w_out_next - OW'(1);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state       <= IDLE;
            r_cmd_ready   <= 1'b0;
            r_addr        <= '0;
            r_words       <= '0;
            r_req_left    <= '0;
            r_wr_idx      <= '0;
            r_last_bcnt   <= '0;
            r_outstanding <= '0;
            r_av_read     <= 1'b0;
            r_burst       <= '0;
        end else begin
            r_outstanding <= w_out_next;
            case (r_state)
                IDLE: begin
                    if (cmd_valid && r_cmd_ready && (cmd_len != '0)) begin
                        r_addr      <= cmd_addr;
                        r_words     <= w_cmd_words;
                        r_req_left  <= w_cmd_words;
                        r_last_bcnt <= w_cmd_bcnt;
                        r_wr_idx    <= '0;
                        r_cmd_ready <= 1'b0;
                        r_state     <= ISSUE;
                    end else begin
                        r_cmd_ready <= 1'b1;
                    end
                end
                ISSUE: begin
                    // After each accept av_read drops so space is re-evaluated.
                    if (r_av_read) begin
                        if (!av_waitrequest) begin
                            r_av_read  <= 1'b0;
                            r_addr     <= r_addr + {23'b0, r_burst, 2'b00};
                            r_req_left <= r_req_left - 15'(r_burst);
                            if (r_req_left == 15'(r_burst)) r_state <= DRAIN;
                        end
                    end else if (w_burst_ok) begin
                        r_av_read <= 1'b1;
                        r_burst   <= w_burst;
                    end
                end
                DRAIN: ;
                default: r_state <= IDLE;
            endcase
            if (w_wr) begin
                if (w_eop) begin
                    r_state     <= IDLE;
                    r_cmd_ready <= 1'b1;
                    r_wr_idx    <= '0;
                end else begin
                    r_wr_idx <= r_wr_idx + 15'd1;
                end
            end
        end
    end

    assign cmd_ready     = r_cmd_ready;
    assign av_address    = r_addr;
    assign av_read       = r_av_read;
    assign av_burstcount = r_burst;
    assign fifo_wrreq    = w_wr;
    assign fifo_data     = w_word;
    assign done          = w_wr && w_eop;

endmodule

// File: tb/tb_eth_avalon_txdma_reader.sv
// Self-checking bench for eth_avalon_txdma_reader: random Avalon slave plus
// a frame-level model of the expected FIFO word stream and request sequence.
module tb_eth_avalon_txdma_reader;

    localparam int unsigned FIFO_AW = 10;
    localparam int unsigned BURST   = 8;
    localparam int unsigned SLACK   = 4;
    localparam int          DEPTH   = 1 << FIFO_AW;

    logic               clk = 1'b0;
    logic               reset_n = 1'b1;
    logic               cmd_valid = 1'b0;
    logic               cmd_ready;
    logic [31:0]        cmd_addr = '0;
    logic [15:0]        cmd_len = '0;
    logic               done;
    logic [31:0]        av_address;
    logic               av_read;
    logic [6:0]         av_burstcount;
    logic               av_waitrequest = 1'b0;
    logic [31:0]        av_readdata = '0;
    logic               av_readdatavalid = 1'b0;
    logic [35:0]        fifo_data;
    logic               fifo_wrreq;
    logic [FIFO_AW-1:0] fifo_wrusedw = '0;
    logic               fifo_wrfull = 1'b0;

    always #5 clk = ~clk;

    eth_avalon_txdma_reader #(
        .FIFO_AW(FIFO_AW),
        .BURST  (BURST),
        .SLACK  (SLACK)
    ) dut (
        .clk             (clk),
        .reset_n         (reset_n),
        .cmd_valid       (cmd_valid),
        .cmd_ready       (cmd_ready),
        .cmd_addr        (cmd_addr),
        .cmd_len         (cmd_len),
        .done            (done),
        .av_address      (av_address),
        .av_read         (av_read),
        .av_burstcount   (av_burstcount),
        .av_waitrequest  (av_waitrequest),
        .av_readdata     (av_readdata),
        .av_readdatavalid(av_readdatavalid),
        .fifo_data       (fifo_data),
        .fifo_wrreq      (fifo_wrreq),
        .fifo_wrusedw    (fifo_wrusedw),
        .fifo_wrfull     (fifo_wrfull)
    );

    int n_vec = 0;
    int n_err = 0;

    logic [35:0] exp_q[$];
    logic [31:0] beat_q[$];
    int          rdy_q[$];
    logic [31:0] req_log[$];
    logic [31:0] exp_addr = '0;
    int          exp_left = 0;
    int          cyc = 0, last_rdy = 0;
    int          out_m = 0, pend_delta = 0;
    int          prev_used = 0, prev_out = 0;
    logic        prev_full = 0, prev_av_read = 0, prev_wait = 0;
    logic [31:0] prev_addr = '0;
    logic [6:0]  prev_bc = '0;
    int          used = 0;
    logic        full = 0;
    int          wait_pct = 0, gap_pct = 0;
    int          force_req_idx = -1, force_cnt = 0, req_idx = 0;
    int          wr_cnt = 0, done_cnt = 0, rd_cycles = 0;
    logic [35:0] first_word = '0, last_word = '0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [31:0] mem(input logic [31:0] a);
        if (a == 32'h0000_2000) return 32'h1122_3344;
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_1234;
    endfunction

    function automatic logic [31:0] mem_fifo(input logic [31:0] a);
        logic [31:0] d;
        d = mem(a);
`ifdef ETH_TXDMA_BSWAP_EN
        return {d[7:0], d[15:8], d[23:16], d[31:24]};
`else
        return d;
`endif
    endfunction

    // One bus cycle: slave drives at the falling edge, outputs are checked 1 time unit later.
    task automatic cycle();
        logic        acc, vld;
        logic [31:0] baddr;
        logic [35:0] w;
        int          bc, lat, freew;
        @(negedge clk);
        cyc++;
        out_m += pend_delta;
        if (prev_av_read && prev_wait) begin
            chk("hold_read", av_read, 1);
            chk("hold_addr", av_address, prev_addr);
            chk("hold_burstcount", av_burstcount, prev_bc);
        end
        if (av_read && !prev_av_read) begin
            freew = DEPTH - prev_used - prev_out;
            chk("space_rule", (!prev_full && freew >= int'(av_burstcount) + int'(SLACK)) ? 1 : 0, 1);
        end
        if (av_read) rd_cycles++;

        av_waitrequest = 1'b0;
        if (av_read) begin
            if (req_idx == force_req_idx && force_cnt < 3) begin
                av_waitrequest = 1'b1;
                force_cnt++;
            end else if ($urandom_range(99) < wait_pct) begin
                av_waitrequest = 1'b1;
            end
        end else begin
            av_waitrequest = 1'($urandom_range(1));
        end

        vld = 1'b0;
        baddr = '0;
        av_readdatavalid = 1'b0;
        av_readdata = $urandom;
        if (beat_q.size() > 0 && rdy_q[0] <= cyc && $urandom_range(99) >= gap_pct) begin
            vld = 1'b1;
            baddr = beat_q.pop_front();
            rdy_q.delete(0);
            av_readdatavalid = 1'b1;
            av_readdata = mem(baddr);
        end

        acc = av_read && !av_waitrequest;
        if (acc) begin
            bc = (exp_left > int'(BURST)) ? int'(BURST) : exp_left;
            chk("req_addr", av_address, exp_addr);
            chk("req_burstcount", av_burstcount, bc);
            req_log.push_back(av_address);
            req_idx++;
            lat = $urandom_range(1, 3);
            if (cyc + lat > last_rdy) last_rdy = cyc + lat;
            for (int i = 0; i < int'(av_burstcount); i++) begin
                beat_q.push_back(av_address + 32'(4 * i));
                rdy_q.push_back(last_rdy);
            end
            exp_addr = exp_addr + 32'(bc * 4);
            exp_left -= bc;
        end

        fifo_wrusedw = FIFO_AW'(used);
        fifo_wrfull  = full;
        #1;
        if (vld) begin
            chk("beat_in_frame", (exp_q.size() > 0) ? 1 : 0, 1);
            if (exp_q.size() > 0) begin
                w = exp_q.pop_front();
                chk("fifo_wrreq", fifo_wrreq, 1);
                chk("fifo_data", fifo_data, w);
                chk("done_on_eop", done, w[35]);
            end
            if (baddr == 32'h0000_2000) begin
`ifdef ETH_TXDMA_BSWAP_EN
                chk("bswap_literal", fifo_data[31:0], 32'h4433_2211);
`else
                chk("passthru_literal", fifo_data[31:0], 32'h1122_3344);
`endif
            end
        end else begin
            chk("wrreq_idle", fifo_wrreq, 0);
            chk("done_idle", done, 0);
        end
        chk("write_under_full", fifo_wrreq & fifo_wrfull, 0);
        if (fifo_wrreq) begin
            if (wr_cnt == 0) first_word = fifo_data;
            last_word = fifo_data;
            wr_cnt++;
        end
        if (done) done_cnt++;

        pend_delta   = (acc ? int'(av_burstcount) : 0) - (vld ? 1 : 0);
        prev_av_read = av_read;
        prev_wait    = av_waitrequest;
        prev_addr    = av_address;
        prev_bc      = av_burstcount;
        prev_used    = used;
        prev_full    = full;
        prev_out     = out_m;
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset_n = 1'b0;
        cmd_valid = 1'b0;
        av_readdatavalid = 1'b0;
        av_waitrequest = 1'b0;
        #1;
        chk("rst_cmd_ready", cmd_ready, 0);
        chk("rst_av_read", av_read, 0);
        chk("rst_av_address", av_address, 0);
        chk("rst_burstcount", av_burstcount, 0);
        chk("rst_wrreq", fifo_wrreq, 0);
        chk("rst_fifo_data", fifo_data, 0);
        chk("rst_done", done, 0);
        exp_q.delete(); beat_q.delete(); rdy_q.delete();
        exp_left = 0; last_rdy = 0; out_m = 0; pend_delta = 0;
        prev_av_read = 0; prev_wait = 0; prev_out = 0;
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        @(posedge clk);
        #1;
        chk("cmd_ready_after_reset", cmd_ready, 1);
    endtask

    task automatic send_cmd(input logic [31:0] addr, input int len);
        logic [35:0] w;
        int words;
        chk("cmd_ready_before_cmd", cmd_ready, 1);
        cmd_valid = 1'b1;
        cmd_addr  = addr;
        cmd_len   = 16'(len);
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
        req_log.delete();
        req_idx = 0; force_cnt = 0; wr_cnt = 0; done_cnt = 0; rd_cycles = 0;
        if (len != 0) begin
            words = (len + 3) / 4;
            for (int i = 0; i < words; i++) begin
                w = '0;
                w[31:0] = mem_fifo(addr + 32'(4 * i));
                w[34]   = (i == 0);
                w[35]   = (i == words - 1);
                if (i == words - 1) w[33:32] = 2'(len - 1);
                exp_q.push_back(w);
            end
            exp_addr = addr;
            exp_left = words;
        end
    endtask

    task automatic finish_frame();
        for (int i = 0; i < 4000 && done_cnt == 0; i++) cycle();
        chk("frame_done", done_cnt, 1);
        chk("frame_words_left", exp_q.size(), 0);
        chk("beats_left", beat_q.size(), 0);
        chk("requests_left", exp_left, 0);
        cycle();
        chk("cmd_ready_after_done", cmd_ready, 1);
    endtask

    task automatic run_frame(input logic [31:0] addr, input int len);
        send_cmd(addr, len);
        finish_frame();
    endtask

    initial begin
        logic [31:0] ra;
        do_reset();

        wait_pct = 0; gap_pct = 0; used = 0; full = 0;
        run_frame(32'h0000_1000, 64);
        chk("len64_requests", req_log.size(), 2);
        chk("len64_req0", req_log[0], 32'h0000_1000);
        chk("len64_req1", req_log[1], 32'h0000_1020);
        chk("len64_writes", wr_cnt, 16);
        chk("len64_sop", first_word[34], 1);
        chk("len64_eop", last_word[35], 1);
        chk("len64_bcnt", last_word[33:32], 3);

        run_frame(32'h0000_1100, 5);
        chk("len5_writes", wr_cnt, 2);
        chk("len5_bcnt", last_word[33:32], 0);

        run_frame(32'h0000_1200, 1);
        chk("len1_writes", wr_cnt, 1);
        chk("len1_sop_eop", first_word[35:32], 4'b1100);

        force_req_idx = 1;
        run_frame(32'h0000_1400, 64);
        force_req_idx = -1;
        chk("wait_cycles_applied", force_cnt, 3);
        chk("wait_requests", req_log.size(), 2);

        send_cmd(32'h0000_1800, 0);
        repeat (10) cycle();
        chk("len0_no_read", rd_cycles, 0);
        chk("len0_no_done", done_cnt, 0);
        chk("len0_ready", cmd_ready, 1);

        full = 1; used = 0;
        send_cmd(32'h0000_1C00, 64);
        repeat (20) cycle();
        chk("no_read_when_full", rd_cycles, 0);
        full = 0; used = 1015;
        repeat (20) cycle();
        chk("no_read_at_1015", rd_cycles, 0);
        used = 1010;
        finish_frame();
        chk("used1010_requests", req_log.size(), 2);
        chk("used1010_req0", req_log[0], 32'h0000_1C00);
        used = 0;

        send_cmd(32'h0000_3000, 64);
        for (int i = 0; i < 2000 && wr_cnt < 5; i++) cycle();
        chk("abort_point", wr_cnt, 5);
        do_reset();
        chk("abort_no_done", done_cnt, 0);
        run_frame(32'h0000_3100, 8);
        chk("restart_sop", first_word[34], 1);
        chk("restart_writes", wr_cnt, 2);

        run_frame(32'h0000_2000, 4);
        run_frame(32'hFFFF_FFF0, 64);
        chk("wrap_req1", req_log[1], 32'h0000_0010);

        wait_pct = 30; gap_pct = 30;
        for (int f = 0; f < 25; f++) begin
            ra = $urandom;
            ra[1:0] = 2'b00;
            used = $urandom_range(1000);
            run_frame(ra, $urandom_range(1, 300));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #5ms;
        $display("FAIL watchdog: simulation time limit reached, got no summary, expected completion");
        $fatal(1);
    end

endmodule

// File: doc/eth_avalon_txdma_reader.md
Name: eth_avalon_txdma_reader

Overview:
- Transmit-side DMA read engine. Fetches one frame buffer from system memory over a pipelined, bursting Avalon-MM read master.
- Pushes tagged 36-bit words into the write port of the transmit dual-clock DMA FIFO. The MAC clock domain drains that FIFO.
- Runs entirely in the Avalon (system) clock domain. It is the memory-reading counterpart of the receive path, which drains the FIFO into memory.

Parameters:
- FIFO_AW, 10, width of FIFO wrusedw; FIFO depth = 2**FIFO_AW words.
- BURST, 8, maximum Avalon burst length in words (power of 2, 1..64).
- SLACK, 4, extra free words required beyond outstanding reads, to cover wrusedw latency.

Ports:
- clk  in  1  system/Avalon clock.
- reset_n  in  1  asynchronous, active-low reset.
- cmd_valid  in  1  start request; accepted when cmd_ready=1.
- cmd_ready  out  1  high in IDLE.
- cmd_addr  in  32  buffer byte address; bits [1:0] must be 0.
- cmd_len  in  16  frame length in bytes, 1..65535 (0 is ignored).
- done  out  1  one-cycle pulse when the last word has been written to the FIFO.
- av_address  out  32  word-aligned read address.
- av_read  out  1  read request.
- av_burstcount  out  7  burst length in words.
- av_waitrequest  in  1  slave stall.
- av_readdata  in  32  read data.
- av_readdatavalid  in  1  read data strobe.
- fifo_data  out  36  [31:0] data, [33:32] valid bytes-1 on the EOP word (0 otherwise), [34] SOP, [35] EOP.
- fifo_wrreq  out  1  FIFO write strobe.
- fifo_wrusedw  in  FIFO_AW  FIFO write-side fill level.
- fifo_wrfull  in  1  FIFO full.

Behaviour:
- Reset: all outputs 0 except cmd_ready=0 during reset, 1 in the first cycle after reset is released. State is IDLE and all counters are 0.
- Command acceptance:
  - cmd_valid & cmd_ready with cmd_len != 0 latches addr and len.
  - Computes words = (len+3)>>2 and last_bytes-1 = (len-1)[1:0].
  - Moves to ISSUE.
  - cmd_len=0 is dropped: stay in IDLE, no done pulse.
- States:
  - IDLE: waits for a command.
  - ISSUE: issues bursts.
  - DRAIN: all requests issued; waits for outstanding data.
  - IDLE again on the last word.
- ISSUE burst rule:
  - burst = min(BURST, words_left_to_request).
  - Assert av_read only if !fifo_wrfull and (2**FIFO_AW - fifo_wrusedw - outstanding) >= burst + SLACK. Compute at FIFO_AW+1 bits, unsigned, saturating at 0.
  - While av_read=1 and av_waitrequest=1, hold av_address, av_burstcount and av_read stable.
  - On accept (av_read & !av_waitrequest):
    - address += burst*4, wrapping modulo 2**32.
    - outstanding += burst.
    - words_left_to_request -= burst.
    - Drop av_read for at least one cycle to re-evaluate space.
  - When words_left_to_request reaches 0, go to DRAIN.
- Data path:
  - Each av_readdatavalid produces, in the same cycle, fifo_wrreq=1 and fifo_data={eop,sop,bcnt,av_readdata}. This is 0 cycles of added latency, combinational from the registered count.
  - outstanding decrements by 1 on each valid.
  - A burst accept and a data valid in the same cycle net to outstanding += burst-1.
  - SOP is set on the first word of the frame. EOP is set on word index words-1; bcnt = last_bytes-1 on that word only.
  - A 1-word frame carries SOP and EOP on the same word.
- Completion: the EOP write pulses done in that cycle and returns to IDLE. cmd_ready=1 from the next cycle.
- The engine never writes while fifo_wrfull. Space accounting guarantees this. A write attempted under full is a design error (bench assertion).
- Data beats with no request outstanding are ignored (assertion).
- Reset mid-frame aborts immediately: no done pulse, and the partial frame stays in the FIFO. The FIFO aclr is driven externally by the same reset.

Optional Feature:
- Macro ETH_TXDMA_BSWAP_EN.
- Defined: av_readdata bytes are reversed ({[7:0],[15:8],[23:16],[31:24]}) before packing into fifo_data[31:0]. The control bits are unaffected. This supports big-endian buffer layout.
- Undefined: data passes straight through.

Decomposition:
- Shared package eth_avalon_txdma_pkg holds:
  - state enum (IDLE, ISSUE, DRAIN);
  - FIFO word field constants (DATA_LSB=0, BCNT_LSB=32, SOP_BIT=34, EOP_BIT=35, WORD_W=36).
- One natural sub-module, eth_avalon_txdma_space: the free-space/outstanding calculator, which outputs burst_ok.
- The FSM and packer stay in the top module.

Test Plan:
- Frame of len=64 at addr 0x1000, zero-wait slave, empty FIFO:
  - Two 8-word bursts at 0x1000 and 0x1020.
  - 16 FIFO writes: SOP on word 0, EOP on word 15 with bcnt=3.
  - One done pulse.
- len=5: two reads; EOP word bcnt=0; len=1: a single word with SOP=EOP=1, bcnt=0.
- av_waitrequest held 3 cycles on the 2nd burst: address and burstcount are stable throughout, no duplicate request, data order preserved.
- fifo_wrusedw=1015 (FIFO_AW=10): no av_read issued. Lowering it to 1010 permits a burst of 8 (1024-1010 >= 8+4) when outstanding=0.
- reset_n asserted after 5 of 16 words, then a new len=8 command: the new frame starts with SOP, and no done is issued for the aborted frame.
- ETH_TXDMA_BSWAP_EN defined: readdata 0x11223344 appears as fifo_data[31:0]=0x44332211.
